// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer and its intersection-sequencer partner:
// FSM state encoding, default timing parameters and the light-state constants.
package phase_timer_pkg;

    localparam int unsigned TICKS_PER_SEC_DEF = 10000;
    localparam int unsigned SEC_W_DEF         = 16;
    localparam int unsigned PRESC_W_DEF       = 14;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_COUNT = 3'd3,
        ST_DONE  = 3'd4,
        ST_IDLE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10,
        LIGHT_OFF    = 2'b11
    } light_t;

endpackage

// File: rtl/phase_timer_sec_prescaler.sv
// Divides the system clock down to one-second strobes; clear forces the count to zero.
module sec_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 10000,
    parameter int unsigned PRESC_W       = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic sec_tick_c
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] count;

    assign sec_tick_c = run && (count == LAST);

    // Count is bounded by LAST so it never wraps past one second.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Phase duration timer: counts secondsToCount whole seconds and strobes finished
// so the light sequencer can advance; exports remaining seconds and a 1 Hz tick.
module phase_timer
    import phase_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int unsigned SEC_W         = SEC_W_DEF,
    parameter int unsigned PRESC_W       = PRESC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_general,
    input  logic [SEC_W-1:0] secondsToCount,
    output logic             finished,
    output logic [SEC_W-1:0] seconds_left,
    output logic             tick_1hz,
    output logic             busy
);

    state_t           state;
    state_t           state_next;
    logic [SEC_W-1:0] seconds_left_next;
    logic             finished_next;
    logic             busy_next;
    logic             run;
    logic             sec_tick_c;

    assign run = (state == ST_COUNT) && enable_general;

    sec_prescaler #(
        .TICKS_PER_SEC (TICKS_PER_SEC),
        .PRESC_W       (PRESC_W)
    ) u_sec_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clear      (!run),
        .run        (run),
        .sec_tick_c (sec_tick_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_START;
            finished     <= 1'b0;
            tick_1hz     <= 1'b0;
            busy         <= 1'b0;
            seconds_left <= '0;
        end else begin
            state        <= state_next;
            finished     <= finished_next;
            tick_1hz     <= sec_tick_c;
            busy         <= busy_next;
            seconds_left <= seconds_left_next;
        end
    end

    // START holds until its pulse has been emitted, which also covers the exit from reset.
    always_comb begin
        state_next        = state;
        seconds_left_next = seconds_left;
        if (!enable_general) begin
            state_next        = ST_IDLE;
            seconds_left_next = '0;
        end else begin
            case (state)
                ST_START: state_next = finished ? ST_WAIT : ST_START;
                ST_WAIT:  state_next = ST_LOAD;
                ST_LOAD: begin
                    seconds_left_next = secondsToCount;
                    state_next        = (secondsToCount == '0) ? ST_DONE : ST_COUNT;
                end
                ST_COUNT: begin
                    if (sec_tick_c) begin
                        if (seconds_left != '0) begin
                            seconds_left_next = seconds_left - SEC_W'(1);
                        end
                        if (seconds_left <= SEC_W'(1)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE:  state_next = ST_WAIT;
                ST_IDLE:  state_next = ST_START;
                default:  state_next = ST_START;
            endcase
        end
        finished_next = (state_next == ST_START) || (state_next == ST_DONE);
        busy_next     = (state_next == ST_LOAD) || (state_next == ST_COUNT);
    end

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with TICKS_PER_SEC=10; expected values are hand-derived
// cycle offsets from each LOAD cycle.
module tb_phase_timer;

    localparam int unsigned TPS   = 10;
    localparam int unsigned SEC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable_general;
    logic [SEC_W-1:0] secondsToCount;
    logic             finished;
    logic [SEC_W-1:0] seconds_left;
    logic             tick_1hz;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic prev_fin = 1'b0;

    phase_timer #(
        .TICKS_PER_SEC (TPS),
        .SEC_W         (SEC_W),
        .PRESC_W       (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_general (enable_general),
        .secondsToCount (secondsToCount),
        .finished       (finished),
        .seconds_left   (seconds_left),
        .tick_1hz       (tick_1hz),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample; every cycle also guards against back-to-back finished.
    task automatic step();
        @(posedge clk);
        #1;
        chk("no_double_finished", {31'b0, finished & prev_fin}, 32'd0);
        prev_fin = finished;
    endtask

    task automatic chk_all(input string tag, input logic f, input logic t,
                           input logic b, input int sl);
        chk({tag, ".finished"}, {31'b0, finished}, {31'b0, f});
        chk({tag, ".tick_1hz"}, {31'b0, tick_1hz}, {31'b0, t});
        chk({tag, ".busy"}, {31'b0, busy}, {31'b0, b});
        chk({tag, ".seconds_left"}, 32'(seconds_left), 32'(sl));
    endtask

    // Entered in a LOAD cycle with secondsToCount == n; leaves in the next LOAD cycle.
    task automatic run_phase(input int n, input int next_n);
        int last;
        last = n * TPS + 1;
        for (int k = 1; k <= last + 2; k++) begin
            step();
            if (k == 1) secondsToCount = SEC_W'(next_n);
            if (k <= last) begin
                chk_all($sformatf("n%0d_k%0d", n, k), k == last,
                        (k >= 11) && (k % 10 == 1), k < last, n - (k - 1) / 10);
            end else if (k == last + 1) begin
                chk_all($sformatf("n%0d_wait", n), 1'b0, 1'b0, 1'b0, 0);
            end else begin
                chk_all($sformatf("n%0d_load", n), 1'b0, 1'b0, 1'b1, 0);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        enable_general = 1'b1;
        secondsToCount = SEC_W'(3);
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 0);

        reset = 1'b0;
        step();
        chk_all("start", 1'b1, 1'b0, 1'b0, 0);
        step();
        chk_all("wait", 1'b0, 1'b0, 1'b0, 0);
        step();
        chk_all("load", 1'b0, 1'b0, 1'b1, 0);

        run_phase(3, 0);
        run_phase(0, 0);
        run_phase(0, 17);
        run_phase(17, 55);

        // 55 must have been picked up at this LOAD despite the mid-phase change.
        for (int k = 1; k <= 25; k++) step();
        chk_all("n55_k25", 1'b0, 1'b0, 1'b1, 53);

        enable_general = 1'b0;
        secondsToCount = SEC_W'(3);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all($sformatf("idle_%0d", k), 1'b0, 1'b0, 1'b0, 0);
        end
        enable_general = 1'b1;
        step();
        chk_all("reenable_start", 1'b1, 1'b0, 1'b0, 0);
        step();
        chk_all("reenable_wait", 1'b0, 1'b0, 1'b0, 0);
        step();
        chk_all("reenable_load", 1'b0, 1'b0, 1'b1, 0);

        for (int k = 1; k <= 11; k++) step();
        chk_all("n3_k11", 1'b0, 1'b1, 1'b1, 2);

        reset = 1'b1;
        step();
        chk_all("midreset", 1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        step();
        chk_all("midreset_start", 1'b1, 1'b0, 1'b0, 0);
        step();
        chk_all("midreset_wait", 1'b0, 1'b0, 1'b0, 0);
        step();
        chk_all("midreset_load", 1'b0, 1'b0, 1'b1, 0);
        step();
        chk_all("midreset_count", 1'b0, 1'b0, 1'b1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
